// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the BRAM-backed synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH      = 7;
    localparam int DEF_ALMOST_FULL_TH  = 120;
    localparam int DEF_ALMOST_EMPTY_TH = 8;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/dual_port_sram_param.sv
// Simple dual-port SRAM: one write port, one registered read port, read-old-data on collision.
module dual_port_sram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  wclk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rclk,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[waddr] <= data_in;
        end
    end

    // Separate process so the read samples the array before the same-edge write lands.
    always_ff @(posedge rclk) begin
        if (ren) begin
            data_out <= mem[raddr];
        end
    end

endmodule

// File: rtl/dual_port_ram_fifo.sv
// Single-clock FIFO on a dual-port SRAM with occupancy count, registered flags and overflow/underflow pulses.
module dual_port_ram_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  loaded;
    logic [DATA_WIDTH-1:0] sram_q;

    assign rd_ok = ren & ~empty;
    assign wr_ok = wen & (~full | rd_ok);

    always_comb begin
        count_nxt = count_q;
        if (wr_ok && !rd_ok) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Flags decode the next count so they line up with the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count_q      <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_TH);
            almost_empty <= (count_nxt <= AE_TH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            loaded     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            overflow   <= wen & ~wr_ok;
            underflow  <= ren & ~rd_ok;
            if (rd_ok) begin
                loaded <= 1'b1;
            end
        end
    end

    dual_port_sram_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .wclk     (clk),
        .wen      (wr_ok),
        .waddr    (wptr),
        .data_in  (din),
        .rclk     (clk),
        .ren      (rd_ok),
        .raddr    (rptr),
        .data_out (sram_q)
    );

    // The SRAM output register is not reset; mask it until a read after reset has refilled it.
    assign dout  = loaded ? sram_q : '0;
    assign count = count_q;

endmodule

// File: tb/tb_dual_port_ram_fifo.sv
// Directed scoreboard bench for dual_port_ram_fifo at default parameters (8 x 128).
module tb_dual_port_ram_fifo;

    localparam int DEPTH = 128;
    localparam int AF_TH = 120;
    localparam int AE_TH = 8;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [7:0] din;
    logic       ren;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q[$];
    int         m_count;
    logic [7:0] m_dout;

    dual_port_ram_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .din          (din),
        .ren          (ren),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_valid, input logic exp_ovf, input logic exp_unf);
        chk("dout_valid",   32'(dout_valid),   32'(exp_valid));
        chk("dout",         32'(dout),         32'(m_dout));
        chk("count",        32'(count),        32'(m_count));
        chk("full",         32'(full),         32'(m_count == DEPTH));
        chk("empty",        32'(empty),        32'(m_count == 0));
        chk("almost_full",  32'(almost_full),  32'(m_count >= AF_TH));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= AE_TH));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        chk("underflow",    32'(underflow),    32'(exp_unf));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_dout  = 8'h00;
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        logic rdok;
        logic wrok;
        wen  = w;
        din  = d;
        ren  = r;
        rdok = r && (m_count != 0);
        wrok = w && ((m_count != DEPTH) || rdok);
        @(posedge clk);
        #1;
        if (rdok) begin
            m_dout = sb_q.pop_front();
            m_count--;
        end
        if (wrok) begin
            sb_q.push_back(d);
            m_count++;
        end
        check_outputs(rdok, w && !wrok, r && !rdok);
        wen = 1'b0;
        ren = 1'b0;
        din = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        din   = 8'h00;
        model_reset();

        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("fill_count", 32'(count), 32'(DEPTH));
        cyc(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain_last", 32'(dout), 32'h7F);

        // wrap-around
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 60; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 60; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("wrap_last", 32'(dout), 32'(8'hA0 + 8'd59));

        // simultaneous read/write while full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        chk("full_rw_dout", 32'(dout), 32'h80);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("full_rw_last", 32'(dout), 32'h55);

        // simultaneous read/write while empty
        cyc(1'b1, 8'h3C, 1'b1);
        chk("empty_rw_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("empty_rw_dout", 32'(dout), 32'h3C);

        // asynchronous reset between clock edges
        for (int i = 0; i < 50; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check_outputs(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_reset_dout", 32'(dout), 32'h11);
        cyc(1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
